writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter LINK_REG, default 31, the destination register for link (jal/jalr) writes.
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the MEM/WB register contents.
REQ-006 The block SHALL have port flush, input, 1 bit: load a bubble into the MEM/WB register.
REQ-007 The block SHALL have port m_valid, input, 1 bit: a valid instruction is presented by MEM.
REQ-008 The block SHALL have ports m_regwrite, m_memtoreg and m_link, inputs, 1 bit each: write enable, load-result select and link select.
REQ-009 The block SHALL have port m_ldtype, input, 3 bits: load type, 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101-111 are treated as lw.
REQ-010 The block SHALL have port m_writereg, input, 5 bits: destination register.
REQ-011 The block SHALL have ports m_aluout, m_readdata and m_pcplus4, inputs, 32 bits each: ALU result/address, raw memory word and PC+4.
REQ-012 The block SHALL have ports WE3, A3 and WD3, outputs of 1, 5 and 32 bits: register-file write enable, address and data.
REQ-013 The block SHALL have port w_valid, output, 1 bit: the WB slot holds a valid instruction.
REQ-014 The block SHALL have port retired, output, CNT_W bits: count of instructions retired.

Function
REQ-015 The MEM/WB register SHALL capture all m_* inputs on the rising clk edge; update priority is reset > flush > stall > capture.
REQ-016 On flush, the block SHALL set w_valid=0 and clear the stored regwrite, independent of stall.
REQ-017 On stall without flush, the block SHALL leave every stored field unchanged.
REQ-018 WE3, A3 and WD3 SHALL depend only on registered state, with no combinational path from m_*, stall or flush; they are stable before the following falling edge, when the register file writes.
REQ-019 The block SHALL drive WE3 = w_valid AND stored regwrite AND (A3 != 0).
REQ-020 The block SHALL drive A3 = LINK_REG when the stored link bit is 1, else the stored writereg.
REQ-021 WD3 SHALL be selected with priority: link gives stored pcplus4 + 4 (mod 2^32); else memtoreg gives the extracted load value; else stored aluout.
REQ-022 Load extraction SHALL be little-endian, using the stored aluout[1:0] as byte offset: lb/lbu take byte readdata[8*off+7:8*off]; lh/lhu take halfword aluout[1] ? [31:16] : [15:0], ignoring aluout[0]; lw takes the whole word.
REQ-023 lb/lh SHALL sign-extend and lbu/lhu SHALL zero-extend to 32 bits.
REQ-024 retired SHALL increment by 1 on each rising edge where w_valid=1 and stall=0, including flush edges, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 Latency SHALL be one cycle: an instruction captured at edge N drives WE3/A3/WD3 during cycle N+1 and is written at that cycle's falling edge.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL clear all MEM/WB fields and retired to 0, giving w_valid=0, WE3=0, A3=0 and WD3=0 from the next cycle.
REQ-027 Reset asserted mid-stall SHALL discard the held instruction, and no write SHALL occur in the cycle after reset.

Verification
REQ-028 A bench SHALL cover: lw, m_writereg=5, m_memtoreg=1, m_readdata=0xDEADBEEF -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; retired +1 one edge later.
REQ-029 A bench SHALL cover: lb with aluout[1:0]=2 and readdata=0x12F45678 -> WD3=0xFFFFFFF4; the same with lbu -> WD3=0x000000F4; lh with aluout=0x2, readdata=0x8001xxxx -> WD3=0xFFFF8001.
REQ-030 A bench SHALL cover: m_link=1, m_pcplus4=0x00400010, m_writereg=0 -> A3=31, WD3=0x00400014, WE3=1.
REQ-031 A bench SHALL cover: m_regwrite=1 with m_writereg=0 -> WE3=0 while w_valid=1.
REQ-032 A bench SHALL cover: stall held 3 cycles with the inputs changing -> WE3/A3/WD3 unchanged and retired unchanged; then flush+stall together -> w_valid=0 next cycle and retired +1.
REQ-033 A bench SHALL cover: retired preset near 2^CNT_W-1 via a short CNT_W=4 build, 16 valid retires -> value wraps to 0; reset during a stream -> outputs 0 the next cycle.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data extraction,
// register-file write port generation and a retired-instruction counter.
module writeback_stage #(
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_regwrite,
    input  logic             m_memtoreg,
    input  logic             m_link,
    input  logic [2:0]       m_ldtype,
    input  logic [4:0]       m_writereg,
    input  logic [31:0]      m_aluout,
    input  logic [31:0]      m_readdata,
    input  logic [31:0]      m_pcplus4,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [31:0]      WD3,
    output logic             w_valid,
    output logic [CNT_W-1:0] retired
);

    logic        w_regwrite;
    logic        w_memtoreg;
    logic        w_link;
    logic [2:0]  w_ldtype;
    logic [4:0]  w_writereg;
    logic [31:0] w_aluout;
    logic [31:0] w_readdata;
    logic [31:0] w_pcplus4;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    // MEM/WB register: reset > flush > stall > capture.
    // A flush only kills valid and regwrite; the payload fields are don't-care
    // once the slot is invalid, so they simply hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
            w_memtoreg <= 1'b0;
            w_link     <= 1'b0;
            w_ldtype   <= 3'd0;
            w_writereg <= 5'd0;
            w_aluout   <= 32'd0;
            w_readdata <= 32'd0;
            w_pcplus4  <= 32'd0;
        end else if (flush) begin
            w_valid    <= 1'b0;
            w_regwrite <= 1'b0;
        end else if (!stall) begin
            w_valid    <= m_valid;
            w_regwrite <= m_regwrite;
            w_memtoreg <= m_memtoreg;
            w_link     <= m_link;
            w_ldtype   <= m_ldtype;
            w_writereg <= m_writereg;
            w_aluout   <= m_aluout;
            w_readdata <= m_readdata;
            w_pcplus4  <= m_pcplus4;
        end
    end

    // Retire count: the WB instruction leaves the slot when it is not held,
    // or when a flush replaces it even while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (w_valid && (!stall || flush)) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Little-endian byte/halfword selection from the stored word.
    always_comb begin
        ld_byte = w_readdata[7:0];
        case (w_aluout[1:0])
            2'd0:    ld_byte = w_readdata[7:0];
            2'd1:    ld_byte = w_readdata[15:8];
            2'd2:    ld_byte = w_readdata[23:16];
            default: ld_byte = w_readdata[31:24];
        endcase
        ld_half = w_aluout[1] ? w_readdata[31:16] : w_readdata[15:0];
    end

    // Sign/zero extension by load type; unknown encodings behave as lw.
    always_comb begin
        load_val = w_readdata;
        case (w_ldtype)
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_val = {16'd0, ld_half};
            3'b011:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {24'd0, ld_byte};
            default: load_val = w_readdata;
        endcase
    end

    // Register-file write port, driven purely from registered state.
    always_comb begin
        A3 = w_link ? 5'(LINK_REG) : w_writereg;
        if (w_link) begin
            WD3 = w_pcplus4 + 32'd4;
        end else if (w_memtoreg) begin
            WD3 = load_val;
        end else begin
            WD3 = w_aluout;
        end
        WE3 = w_valid && w_regwrite && (A3 != 5'd0);
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand-written
// stall/flush/reset/wrap sequences and randomized traffic against a model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        m_valid, m_regwrite, m_memtoreg, m_link;
    logic [2:0]  m_ldtype;
    logic [4:0]  m_writereg;
    logic [31:0] m_aluout, m_readdata, m_pcplus4;

    logic        WE3, w_valid;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] retired;

    logic        WE3_s, w_valid_s;
    logic [4:0]  A3_s;
    logic [31:0] WD3_s;
    logic [3:0]  retired_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_stage #(.LINK_REG(31), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_link(m_link), .m_ldtype(m_ldtype), .m_writereg(m_writereg),
        .m_aluout(m_aluout), .m_readdata(m_readdata), .m_pcplus4(m_pcplus4),
        .WE3(WE3), .A3(A3), .WD3(WD3), .w_valid(w_valid), .retired(retired)
    );

    writeback_stage #(.LINK_REG(31), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_link(m_link), .m_ldtype(m_ldtype), .m_writereg(m_writereg),
        .m_aluout(m_aluout), .m_readdata(m_readdata), .m_pcplus4(m_pcplus4),
        .WE3(WE3_s), .A3(A3_s), .WD3(WD3_s), .w_valid(w_valid_s), .retired(retired_s)
    );

    // Reference model: the instruction sitting in WB, plus a retire count.
    typedef struct {
        bit          v, rw, mtr, lk;
        bit [2:0]    ld;
        bit [4:0]    wr;
        bit [31:0]   alu, rd, pc;
    } instr_t;

    instr_t      wb;
    bit [31:0]   m_ret;
    bit          just_reset;

    function automatic bit [31:0] load_value(instr_t i);
        int unsigned off, b, h;
        off = i.alu % 4;
        b = (i.rd >> (8 * off)) % 256;
        h = ((i.alu % 4) >= 2) ? (i.rd >> 16) : (i.rd % 65536);
        case (i.ld)
            3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
            3'd2:    return 32'(h);
            3'd3:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
            3'd4:    return 32'(b);
            default: return i.rd;
        endcase
    endfunction

    function automatic bit [4:0] exp_a3(instr_t i);
        return i.lk ? 5'd31 : i.wr;
    endfunction

    function automatic bit [31:0] exp_wd(instr_t i);
        if (i.lk) return i.pc + 32'd4;
        if (i.mtr) return load_value(i);
        return i.alu;
    endfunction

    function automatic bit exp_we(instr_t i);
        return i.v && i.rw && (exp_a3(i) != 5'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            wb = '{default: '0};
            m_ret = 0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (wb.v && (!stall || flush)) m_ret++;
            if (flush) begin
                wb.v = 1'b0;
                wb.rw = 1'b0;
            end else if (!stall) begin
                wb.v = m_valid; wb.rw = m_regwrite; wb.mtr = m_memtoreg;
                wb.lk = m_link; wb.ld = m_ldtype; wb.wr = m_writereg;
                wb.alu = m_aluout; wb.rd = m_readdata; wb.pc = m_pcplus4;
            end
        end
    endtask

    task automatic check_model();
        check("w_valid", 32'(w_valid), 32'(wb.v));
        check("WE3", 32'(WE3), 32'(exp_we(wb)));
        check("retired", retired, m_ret);
        check("retired_cnt4", 32'(retired_s), 32'(m_ret % 16));
        if (wb.v || just_reset) begin
            check("A3", 32'(A3), 32'(exp_a3(wb)));
            check("WD3", WD3, exp_wd(wb));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_instr(input bit v, rw, mtr, lk, input bit [2:0] ld, input bit [4:0] wr,
                             input bit [31:0] alu, rd, pc);
        m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_link = lk;
        m_ldtype = ld; m_writereg = wr; m_aluout = alu; m_readdata = rd; m_pcplus4 = pc;
    endtask

    task automatic rand_instr();
        set_instr(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                  3'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom, $urandom);
    endtask

    typedef struct {
        string     name;
        bit        rw, mtr, lk;
        bit [2:0]  ld;
        bit [4:0]  wr;
        bit [31:0] alu, rd, pc;
        bit        e_we;
        bit [4:0]  e_a3;
        bit [31:0] e_wd;
    } vec_t;

    vec_t vecs[8];
    bit [31:0] ret_snap;

    initial begin
        vecs[0] = '{"lw",        1, 1, 0, 3'd0, 5'd5,  32'h0000_1000, 32'hDEADBEEF, 32'h0, 1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{"lb_off2",   1, 1, 0, 3'd3, 5'd7,  32'h0000_0002, 32'h12F45678, 32'h0, 1, 5'd7,  32'hFFFFFFF4};
        vecs[2] = '{"lbu_off2",  1, 1, 0, 3'd4, 5'd7,  32'h0000_0002, 32'h12F45678, 32'h0, 1, 5'd7,  32'h000000F4};
        vecs[3] = '{"lh_hi",     1, 1, 0, 3'd1, 5'd8,  32'h0000_0002, 32'h8001ABCD, 32'h0, 1, 5'd8,  32'hFFFF8001};
        vecs[4] = '{"link",      1, 0, 1, 3'd0, 5'd0,  32'h0000_0077, 32'h0,        32'h00400010, 1, 5'd31, 32'h00400014};
        vecs[5] = '{"wr_x0",     1, 0, 0, 3'd0, 5'd0,  32'h0000_0055, 32'h0,        32'h0, 0, 5'd0,  32'h00000055};
        vecs[6] = '{"lhu_lo",    1, 1, 0, 3'd2, 5'd9,  32'h0000_0001, 32'h1234F00D, 32'h0, 1, 5'd9,  32'h0000F00D};
        vecs[7] = '{"lb_off3",   1, 1, 0, 3'd3, 5'd12, 32'h0000_0003, 32'h80ABCDEF, 32'h0, 1, 5'd12, 32'hFFFFFF80};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset_we", 32'(WE3), 32'd0);
        check("reset_a3", 32'(A3), 32'd0);
        check("reset_wd", WD3, 32'd0);
        reset = 1'b0;

        // Directed vectors, each followed by one edge to observe the retire.
        foreach (vecs[k]) begin
            set_instr(1, vecs[k].rw, vecs[k].mtr, vecs[k].lk, vecs[k].ld, vecs[k].wr,
                      vecs[k].alu, vecs[k].rd, vecs[k].pc);
            tick();
            check({vecs[k].name, "_valid"}, 32'(w_valid), 32'd1);
            check({vecs[k].name, "_we"}, 32'(WE3), 32'(vecs[k].e_we));
            check({vecs[k].name, "_a3"}, 32'(A3), 32'(vecs[k].e_a3));
            check({vecs[k].name, "_wd"}, WD3, vecs[k].e_wd);
            ret_snap = m_ret;
            m_valid = 1'b0;
            tick();
            check({vecs[k].name, "_retire"}, retired, ret_snap + 32'd1);
        end

        // Stall for three cycles with changing inputs, then flush+stall.
        set_instr(1, 1, 0, 0, 3'd0, 5'd10, 32'hCAFE0001, 32'h0, 32'h0);
        tick();
        ret_snap = m_ret;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_instr();
            tick();
            check("stall_we", 32'(WE3), 32'd1);
            check("stall_a3", 32'(A3), 32'd10);
            check("stall_wd", WD3, 32'hCAFE0001);
            check("stall_ret", retired, ret_snap);
        end
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 32'(w_valid), 32'd0);
        check("flush_stall_ret", retired, ret_snap + 32'd1);
        flush = 1'b0; stall = 1'b0;

        // Reset arriving while an instruction is held by stall.
        set_instr(1, 1, 0, 0, 3'd0, 5'd3, 32'h1234, 32'h0, 32'h0);
        tick();
        stall = 1'b1; reset = 1'b1;
        tick();
        check("rst_stall_we", 32'(WE3), 32'd0);
        check("rst_stall_ret", retired, 32'd0);
        reset = 1'b0; stall = 1'b0; m_valid = 1'b0;
        tick();
        check("post_rst_we", 32'(WE3), 32'd0);

        // Narrow counter wrap: 17 consecutive valid captures from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            set_instr(1, 1, 0, 0, 3'd0, 5'(n), 32'(n), 32'h0, 32'h0);
            tick();
            if (n == 16) check("cnt4_at_max", 32'(retired_s), 32'd15);
            if (n == 17) check("cnt4_wrap", 32'(retired_s), 32'd0);
        end

        // Reset in the middle of a stream.
        reset = 1'b1;
        tick();
        check("stream_rst_valid", 32'(w_valid), 32'd0);
        check("stream_rst_wd", WD3, 32'd0);
        reset = 1'b0;

        // Randomized traffic.
        for (int r = 0; r < 400; r++) begin
            rand_instr();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
